// File: rtl/hazard_stall_control_pkg.sv
// Shared core definitions: RV32I opcodes, write-back selector, hazard FSM
// states and the register-read classification also used by forwarding.
package hazard_stall_control_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4,
    NO_WRITEBACK
  } write_back_mux_selector;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    TIMEOUT
  } hazard_state_e;

  // Instructions whose rs1 field names a real source register.
  function automatic logic reads_rs1(input logic [6:0] opcode);
    logic r;
    case (opcode)
      OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE,
      OPCODE_LOAD, OPCODE_JALR, OPCODE_OPIMM: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  // Instructions whose rs2 field names a real source register.
  function automatic logic reads_rs2(input logic [6:0] opcode);
    logic r;
    case (opcode)
      OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Hazard performance counters: load-use stalls, redirect flushes and
// memory-wait cycles. Present only when HAZARD_PERF_CNT_EN is defined.
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_pulse,
  input  logic        flush_pulse,
  input  logic        memwait_pulse,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic [31:0] memwait_cnt
);

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      memwait_cnt <= '0;
    end else begin
      if (stall_pulse)   stall_cnt   <= stall_cnt + 32'd1;
      if (flush_pulse)   flush_cnt   <= flush_cnt + 32'd1;
      if (memwait_pulse) memwait_cnt <= memwait_cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/hazard_stall_control.sv
// Pipeline sequencing controller: per-cycle advance/hold/bubble decisions
// for load-use, taken redirects and multi-cycle data-memory accesses, with
// a watchdog that turns a hung access into a sticky error.
// Optional feature: HAZARD_PERF_CNT_EN enables the perf counter outputs.
module hazard_stall_control
  import hazard_stall_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  ID_opcode_ip,
  input  logic [4:0]  ID_rs1_ip,
  input  logic [4:0]  ID_rs2_ip,
  input  logic [6:0]  EX_opcode_ip,
  input  logic [4:0]  EX_dest_ip,
  input  logic        EX_redirect_ip,
  input  logic        dmem_req_ip,
  input  logic        dmem_ready_ip,
  output logic        pc_en_op,
  output logic        if_id_en_op,
  output logic        if_id_flush_op,
  output logic        id_ex_en_op,
  output logic        id_ex_bubble_op,
  output logic        ex_mem_en_op,
  output logic        mem_wb_bubble_op,
  output logic        mem_timeout_op,
  output logic [31:0] stall_cnt_op,
  output logic [31:0] flush_cnt_op,
  output logic [31:0] memwait_cnt_op
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  hazard_state_e    state_q, state_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             load_use;
  logic             freeze;
  logic             redirect_take;
  logic             load_use_take;

  // A load in EX feeds a register the ID instruction really reads; x0 never does.
  assign load_use = (EX_opcode_ip == OPCODE_LOAD) && (EX_dest_ip != 5'd0) &&
                    ((reads_rs1(ID_opcode_ip) && (ID_rs1_ip == EX_dest_ip)) ||
                     (reads_rs2(ID_opcode_ip) && (ID_rs2_ip == EX_dest_ip)));

  // State and watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  // Next state, watchdog update and Mealy enables; freeze > redirect > load-use.
  always_comb begin
    state_d          = state_q;
    wdog_d           = wdog_q;
    freeze           = 1'b0;
    redirect_take    = 1'b0;
    load_use_take    = 1'b0;
    pc_en_op         = 1'b1;
    if_id_en_op      = 1'b1;
    if_id_flush_op   = 1'b0;
    id_ex_en_op      = 1'b1;
    id_ex_bubble_op  = 1'b0;
    ex_mem_en_op     = 1'b1;
    mem_wb_bubble_op = 1'b0;
    mem_timeout_op   = 1'b0;

    if (!reset) begin
      case (state_q)
        RUN: begin
          if (dmem_req_ip && !dmem_ready_ip) begin
            freeze  = 1'b1;
            state_d = MEM_WAIT;
            wdog_d  = CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          // The release cycle is handled exactly like RUN with a ready memory.
          if (dmem_ready_ip) begin
            state_d = RUN;
          end else begin
            freeze = 1'b1;
            if (wdog_q == TIMEOUT_VAL) begin
              state_d = TIMEOUT;
            end else begin
              wdog_d = wdog_q + CNT_W'(1);
            end
          end
        end
        TIMEOUT: begin
          freeze         = 1'b1;
          mem_timeout_op = 1'b1;
        end
        default: begin
          state_d = RUN;
        end
      endcase

      // A frozen EX cannot act on redirect or load-use; both re-evaluate later.
      redirect_take = !freeze && EX_redirect_ip;
      load_use_take = !freeze && !EX_redirect_ip && load_use;

      if (freeze) begin
        pc_en_op         = 1'b0;
        if_id_en_op      = 1'b0;
        id_ex_en_op      = 1'b0;
        ex_mem_en_op     = 1'b0;
        mem_wb_bubble_op = 1'b1;
      end else if (redirect_take) begin
        if_id_flush_op  = 1'b1;
        id_ex_bubble_op = 1'b1;
      end else if (load_use_take) begin
        pc_en_op        = 1'b0;
        if_id_en_op     = 1'b0;
        id_ex_bubble_op = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic        memwait_pulse;
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

  // TIMEOUT cycles are a dead core, not memory latency, so they are not counted.
  assign memwait_pulse = freeze && (state_q != TIMEOUT);

  hazard_perf_counters u_perf (
    .clk           (clk),
    .reset         (reset),
    .stall_pulse   (load_use_take),
    .flush_pulse   (redirect_take),
    .memwait_pulse (memwait_pulse),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .memwait_cnt   (memwait_cnt)
  );

  assign stall_cnt_op   = reset ? 32'd0 : stall_cnt;
  assign flush_cnt_op   = reset ? 32'd0 : flush_cnt;
  assign memwait_cnt_op = reset ? 32'd0 : memwait_cnt;
`else
  assign stall_cnt_op   = 32'd0;
  assign flush_cnt_op   = 32'd0;
  assign memwait_cnt_op = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_control.sv
// Scoreboard bench for hazard_stall_control: a stimulus process predicts each
// cycle's outputs from the hazard rules and queues them; a monitor compares.
module tb_hazard_stall_control;
  import hazard_stall_control_pkg::*;

  localparam int MEM_TIMEOUT = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [6:0]  ID_opcode_ip, EX_opcode_ip;
  logic [4:0]  ID_rs1_ip, ID_rs2_ip, EX_dest_ip;
  logic        EX_redirect_ip, dmem_req_ip, dmem_ready_ip;
  logic        pc_en_op, if_id_en_op, if_id_flush_op, id_ex_en_op;
  logic        id_ex_bubble_op, ex_mem_en_op, mem_wb_bubble_op, mem_timeout_op;
  logic [31:0] stall_cnt_op, flush_cnt_op, memwait_cnt_op;

  hazard_stall_control #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .ID_opcode_ip     (ID_opcode_ip),
    .ID_rs1_ip        (ID_rs1_ip),
    .ID_rs2_ip        (ID_rs2_ip),
    .EX_opcode_ip     (EX_opcode_ip),
    .EX_dest_ip       (EX_dest_ip),
    .EX_redirect_ip   (EX_redirect_ip),
    .dmem_req_ip      (dmem_req_ip),
    .dmem_ready_ip    (dmem_ready_ip),
    .pc_en_op         (pc_en_op),
    .if_id_en_op      (if_id_en_op),
    .if_id_flush_op   (if_id_flush_op),
    .id_ex_en_op      (id_ex_en_op),
    .id_ex_bubble_op  (id_ex_bubble_op),
    .ex_mem_en_op     (ex_mem_en_op),
    .mem_wb_bubble_op (mem_wb_bubble_op),
    .mem_timeout_op   (mem_timeout_op),
    .stall_cnt_op     (stall_cnt_op),
    .flush_cnt_op     (flush_cnt_op),
    .memwait_cnt_op   (memwait_cnt_op)
  );

  typedef struct {
    logic [6:0]  ctl;   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble}
    logic        tmo;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [31:0] mw;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: a pending access, its stuck-cycle count, the error.
  bit          m_pending = 0;
  int          m_stuck   = 0;
  bit          m_tmo     = 0;
  logic [31:0] m_stall = 0, m_flush = 0, m_mw = 0;

  function automatic bit uses_rs1(input logic [6:0] op);
    return op inside {OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE,
                      OPCODE_LOAD, OPCODE_JALR, OPCODE_OPIMM};
  endfunction

  function automatic bit uses_rs2(input logic [6:0] op);
    return op inside {OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE};
  endfunction

  task automatic cycle(input logic rst, input logic [6:0] idop,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [6:0] exop, input logic [4:0] rd,
                       input logic redir, input logic req, input logic rdy);
    exp_t e;
    bit   frz, hz;
    bit   pc, ii, fl, ie, bb, em, wb;
    @(posedge clk);
    #1;
    reset = rst; ID_opcode_ip = idop; ID_rs1_ip = r1; ID_rs2_ip = r2;
    EX_opcode_ip = exop; EX_dest_ip = rd; EX_redirect_ip = redir;
    dmem_req_ip = req; dmem_ready_ip = rdy;
    pc = 1; ii = 1; fl = 0; ie = 1; bb = 0; em = 1; wb = 0;
    e.stall = PERF ? m_stall : 32'd0;
    e.flush = PERF ? m_flush : 32'd0;
    e.mw    = PERF ? m_mw    : 32'd0;
    e.tmo   = m_tmo;
    if (rst) begin
      e.tmo = 0; e.stall = 0; e.flush = 0; e.mw = 0;
      m_pending = 0; m_stuck = 0; m_tmo = 0;
      m_stall = 0; m_flush = 0; m_mw = 0;
    end else begin
      frz = m_tmo || ((m_pending || req) && !rdy);
      hz  = (exop == OPCODE_LOAD) && (rd != 0) &&
            ((uses_rs1(idop) && r1 == rd) || (uses_rs2(idop) && r2 == rd));
      if (frz) begin
        pc = 0; ii = 0; ie = 0; em = 0; wb = 1;
        if (!m_tmo) m_mw++;
      end else if (redir) begin
        fl = 1; bb = 1;
        m_flush++;
      end else if (hz) begin
        pc = 0; ii = 0; bb = 1;
        m_stall++;
      end
      // An access stuck for more than MEM_TIMEOUT+entry cycles kills the core.
      if (!m_tmo) begin
        if ((m_pending || req) && !rdy) begin
          m_pending = 1;
          m_stuck++;
          if (m_stuck > MEM_TIMEOUT) m_tmo = 1;
        end else begin
          m_pending = 0;
          m_stuck   = 0;
        end
      end
    end
    e.ctl = {pc, ii, fl, ie, bb, em, wb};
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: the DUT presents outputs every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("ctl", 32'({pc_en_op, if_id_en_op, if_id_flush_op, id_ex_en_op,
                        id_ex_bubble_op, ex_mem_en_op, mem_wb_bubble_op}), 32'(e.ctl));
      check("timeout", 32'(mem_timeout_op), 32'(e.tmo));
      check("stall_cnt", stall_cnt_op, e.stall);
      check("flush_cnt", flush_cnt_op, e.flush);
      check("memwait_cnt", memwait_cnt_op, e.mw);
    end
  end

  logic [6:0] ops [11];

  initial begin
    int budget;
    ops = '{OPCODE_LOAD, OPCODE_OPIMM, OPCODE_AUIPC, OPCODE_STORE, OPCODE_OP,
            OPCODE_LUI, OPCODE_BRANCH, OPCODE_JALR, OPCODE_JAL, OPCODE_SYSTEM, 7'h7f};
    reset = 1; ID_opcode_ip = 0; ID_rs1_ip = 0; ID_rs2_ip = 0; EX_opcode_ip = 0;
    EX_dest_ip = 0; EX_redirect_ip = 0; dmem_req_ip = 0; dmem_ready_ip = 0;

    // Reset with hazard-looking inputs: outputs must stay at reset values.
    cycle(1, OPCODE_OP, 5'd5, 5'd5, OPCODE_LOAD, 5'd5, 1, 1, 0);
    cycle(1, OPCODE_OP, 5'd0, 5'd0, OPCODE_OP, 5'd0, 0, 0, 0);

    // Load-use on rs2, then EX becomes OP.
    cycle(0, OPCODE_OP, 5'd1, 5'd5, OPCODE_LOAD, 5'd5, 0, 0, 0);
    cycle(0, OPCODE_OP, 5'd1, 5'd5, OPCODE_OP, 5'd5, 0, 0, 0);
    // Redirect beats load-use.
    cycle(0, OPCODE_OP, 5'd7, 5'd2, OPCODE_LOAD, 5'd7, 1, 0, 0);
    cycle(0, OPCODE_OP, 5'd7, 5'd2, OPCODE_OP, 5'd7, 0, 0, 0);
    // Three-cycle wait with a load-use pending underneath, then ready.
    for (int i = 0; i < 3; i++) cycle(0, OPCODE_OP, 5'd4, 5'd2, OPCODE_LOAD, 5'd4, 0, 1, 0);
    cycle(0, OPCODE_OP, 5'd4, 5'd2, OPCODE_LOAD, 5'd4, 0, 1, 1);
    // Zero-wait access.
    cycle(0, OPCODE_OP, 5'd1, 5'd2, OPCODE_OP, 5'd3, 0, 1, 1);
    // No false hazards: x0 and LUI.
    cycle(0, OPCODE_OPIMM, 5'd0, 5'd0, OPCODE_LOAD, 5'd0, 0, 0, 0);
    cycle(0, OPCODE_LUI, 5'd3, 5'd3, OPCODE_LOAD, 5'd3, 0, 0, 0);
    // Reset mid-wait.
    cycle(0, OPCODE_OP, 5'd1, 5'd2, OPCODE_OP, 5'd3, 0, 1, 0);
    cycle(0, OPCODE_OP, 5'd1, 5'd2, OPCODE_OP, 5'd3, 0, 1, 0);
    cycle(1, OPCODE_OP, 5'd1, 5'd2, OPCODE_OP, 5'd3, 0, 1, 0);
    cycle(0, OPCODE_OP, 5'd1, 5'd2, OPCODE_OP, 5'd3, 0, 0, 0);
    // Watchdog: ready held low, then rising ready does not clear the error.
    for (int i = 0; i < 7; i++) cycle(0, OPCODE_OP, 5'd1, 5'd2, OPCODE_OP, 5'd3, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, OPCODE_OP, 5'd1, 5'd2, OPCODE_OP, 5'd3, 1, 1, 1);
    cycle(1, OPCODE_OP, 5'd1, 5'd2, OPCODE_OP, 5'd3, 0, 0, 0);
    cycle(0, OPCODE_OP, 5'd1, 5'd2, OPCODE_OP, 5'd3, 0, 0, 0);

    // Randomized traffic with small register numbers to provoke hits.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 99) < 3),
            ops[$urandom_range(0, 10)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1) ? OPCODE_LOAD : ops[$urandom_range(0, 10)],
            5'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 55));
    end

    budget = 20;
    while (sb_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
